// File: rtl/weight_stream_loader_pkg.sv
// Shared types and defaults for the weight stream loader (FSM encoding, layer defaults).
// Optional checksum support is enabled by defining WLOAD_CHECKSUM_EN.
package weight_stream_loader_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } load_state_t;

    localparam int DEF_COEFF_WIDTH = 16;
    localparam int DEF_KERN_SIZE   = 9;

    // Per-bank checksum width: coefficient width plus enough headroom for KERN_SIZE words.
    function automatic int sum_width(input int coeff_width, input int kern_size);
        return coeff_width + $clog2(kern_size) + 1;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Two-bank kernel store: one write port, one synchronous read port.
// The address MSB selects the bank, so each bank occupies a power-of-two region.
module weight_bank_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW:0]      waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW:0]      raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Pops coefficients from an ap_fifo read port into a double-buffered kernel store.
// Define WLOAD_CHECKSUM_EN to add per-bank sums and the bank_sum output.
module weight_stream_loader
    import weight_stream_loader_pkg::*;
#(
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int KERN_SIZE   = DEF_KERN_SIZE
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [COEFF_WIDTH-1:0]       input_V_dout,
    input  logic                         input_V_empty_n,
    output logic                         input_V_read,
    output logic                         bank_valid,
    input  logic                         rd_en,
    input  logic [$clog2(KERN_SIZE)-1:0] rd_addr,
    output logic [COEFF_WIDTH-1:0]       rd_data,
    input  logic                         bank_release
`ifdef WLOAD_CHECKSUM_EN
    ,
    output logic [COEFF_WIDTH+$clog2(KERN_SIZE):0] bank_sum
`endif
);

    localparam int AW = $clog2(KERN_SIZE);
    localparam int SW = sum_width(COEFF_WIDTH, KERN_SIZE);
    localparam logic [AW-1:0] LAST_IDX = AW'(KERN_SIZE - 1);

    load_state_t     state_reg, state_next;
    logic            active_reg;
    logic            wr_bank_reg, wr_bank_next;
    logic            rd_bank_reg, rd_bank_next;
    logic [1:0]      full_reg, full_next;
    logic [AW-1:0]   wr_cnt_reg, wr_cnt_next;
    logic            rd_zero_reg;
    logic            rd_in_range;
    logic            fill_done;
    logic [COEFF_WIDTH-1:0] ram_q;

    assign bank_valid  = full_reg[rd_bank_reg];
    assign rd_in_range = int'(rd_addr) < KERN_SIZE;
    assign fill_done   = input_V_read && (wr_cnt_reg == LAST_IDX);

    always_comb begin
        state_next   = state_reg;
        wr_bank_next = wr_bank_reg;
        wr_cnt_next  = wr_cnt_reg;
        rd_bank_next = rd_bank_reg;
        full_next    = full_reg;
        input_V_read = 1'b0;

        case (state_reg)
            ST_FILL: input_V_read = active_reg && input_V_empty_n;
            ST_WAIT: if (!full_reg[wr_bank_reg]) state_next = ST_FILL;
            default: state_next = ST_FILL;
        endcase

        if (input_V_read) begin
            if (fill_done) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_cnt_next            = '0;
                wr_bank_next           = ~wr_bank_reg;
            end else begin
                wr_cnt_next = wr_cnt_reg + AW'(1);
            end
        end

        // A release always targets the other bank than a completing fill, so both apply.
        if (bank_release && bank_valid) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = ~rd_bank_reg;
        end

        if (fill_done) begin
            state_next = full_next[wr_bank_next] ? ST_WAIT : ST_FILL;
        end
    end

    // active_reg keeps the FIFO pop low while reset is asserted and for the first clock after.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg   <= ST_FILL;
            active_reg  <= 1'b0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
            wr_cnt_reg  <= '0;
            rd_zero_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            active_reg  <= 1'b1;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            full_reg    <= full_next;
            wr_cnt_reg  <= wr_cnt_next;
            if (rd_en) begin
                rd_zero_reg <= !(bank_valid && rd_in_range);
            end
        end
    end

    weight_bank_ram #(
        .WIDTH (COEFF_WIDTH),
        .AW    (AW)
    ) u_bank_ram (
        .clk   (ap_clk),
        .we    (input_V_read),
        .waddr ({wr_bank_reg, wr_cnt_reg}),
        .wdata (input_V_dout),
        .re    (rd_en),
        .raddr ({rd_bank_reg, rd_addr}),
        .rdata (ram_q)
    );

    assign rd_data = rd_zero_reg ? '0 : ram_q;

`ifdef WLOAD_CHECKSUM_EN
    logic [SW-1:0] sum_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_sum
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    sum_reg[gi] <= '0;
                end else if (input_V_read && (wr_bank_reg == 1'(gi))) begin
                    // The first word of a fill restarts the accumulator for that bank.
                    sum_reg[gi] <= ((wr_cnt_reg == '0) ? '0 : sum_reg[gi]) + SW'(input_V_dout);
                end
            end
        end
    endgenerate

    assign bank_sum = bank_valid ? sum_reg[rd_bank_reg] : '0;
`else
    // Plain loader: no accumulators.
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomized and directed bench for weight_stream_loader against a kernel-queue model.
// Checks bank_sum as well when WLOAD_CHECKSUM_EN is defined.
module tb_weight_stream_loader;

    localparam int CW = 16;
    localparam int KS = 4;
    localparam int AW = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [CW-1:0] input_V_dout;
    logic          input_V_empty_n;
    logic          input_V_read;
    logic          bank_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          bank_release;
`ifdef WLOAD_CHECKSUM_EN
    logic [CW+AW:0] bank_sum;
    logic [CW+3:0]  bank_sum5;
`endif

    // Second instance with KERN_SIZE=5 so out-of-range read addresses are reachable.
    logic [CW-1:0] dout5;
    logic          empty_n5;
    logic          read5;
    logic          valid5;
    logic          rd_en5;
    logic [2:0]    rd_addr5;
    logic [CW-1:0] rd_data5;

    always #5 ap_clk = ~ap_clk;

    weight_stream_loader #(.COEFF_WIDTH(CW), .KERN_SIZE(KS)) u_dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .input_V_dout    (input_V_dout),
        .input_V_empty_n (input_V_empty_n),
        .input_V_read    (input_V_read),
        .bank_valid      (bank_valid),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .bank_release    (bank_release)
`ifdef WLOAD_CHECKSUM_EN
        ,
        .bank_sum        (bank_sum)
`endif
    );

    weight_stream_loader #(.COEFF_WIDTH(CW), .KERN_SIZE(5)) u_dut5 (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .input_V_dout    (dout5),
        .input_V_empty_n (empty_n5),
        .input_V_read    (read5),
        .bank_valid      (valid5),
        .rd_en           (rd_en5),
        .rd_addr         (rd_addr5),
        .rd_data         (rd_data5),
        .bank_release    (1'b0)
`ifdef WLOAD_CHECKSUM_EN
        ,
        .bank_sum        (bank_sum5)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: FIFO contents, the kernel being assembled, and up to two completed kernels.
    logic [CW-1:0] fifo_q[$];
    logic [CW-1:0] cur_k[$];
    logic [CW-1:0] ready_m [2][KS];
    int            ready_cnt = 0;
    logic [CW-1:0] exp_rd = '0;
    bit            feed_en = 1'b0;
    int            pop_cnt = 0;
    int            cyc_n = 0;
    int            pop_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW+AW:0] model_sum();
        logic [CW+AW:0] s = '0;
        for (int i = 0; i < KS; i++) s += (CW+AW+1)'(ready_m[0][i]);
        return s;
    endfunction

    // One clock: starts and ends 1 time unit after a rising edge.
    task automatic cycle();
        logic popped;
        logic rel_ok;
        input_V_empty_n = feed_en && (fifo_q.size() > 0);
        input_V_dout    = (fifo_q.size() > 0) ? fifo_q[0] : CW'($urandom);
        @(negedge ap_clk);
        popped = input_V_read;
        check("pop_allowed", 32'(input_V_read & ~(input_V_empty_n & (ready_cnt < 2))), 0);
        if (rd_en) exp_rd = (ready_cnt > 0 && int'(rd_addr) < KS) ? ready_m[0][rd_addr] : '0;
        rel_ok = bank_release && (ready_cnt > 0);
        @(posedge ap_clk);
        #1;
        cyc_n++;
        if (popped && fifo_q.size() > 0) begin
            pop_cnt++;
            pop_cyc_q.push_back(cyc_n);
            cur_k.push_back(fifo_q.pop_front());
            if (cur_k.size() == KS && ready_cnt < 2) begin
                for (int i = 0; i < KS; i++) ready_m[ready_cnt][i] = cur_k[i];
                ready_cnt++;
                cur_k.delete();
            end
        end
        if (rel_ok) begin
            for (int i = 0; i < KS; i++) ready_m[0][i] = ready_m[1][i];
            ready_cnt--;
        end
        check("bank_valid", 32'(bank_valid), 32'(ready_cnt > 0));
        check("rd_data", 32'(rd_data), 32'(exp_rd));
`ifdef WLOAD_CHECKSUM_EN
        check("bank_sum", 32'(bank_sum), (ready_cnt > 0) ? 32'(model_sum()) : 0);
`endif
        rd_en        = 1'b0;
        bank_release = 1'b0;
    endtask

    task automatic run_pops(input int n, input int bound, input string tag);
        int start = pop_cnt;
        for (int k = 0; k < bound && (pop_cnt - start) < n; k++) cycle();
        check(tag, pop_cnt - start, n);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        for (int k = 0; k < bound && ready_cnt == 0; k++) cycle();
        check(tag, 32'(bank_valid), 1);
    endtask

    task automatic model_clear();
        fifo_q.delete();
        cur_k.delete();
        ready_cnt = 0;
        exp_rd    = '0;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_read", 32'(input_V_read), 0);
        check("rst_valid", 32'(bank_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
`ifdef WLOAD_CHECKSUM_EN
        check("rst_sum", 32'(bank_sum), 0);
`endif
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic read_all(input string tag, input logic [CW-1:0] base);
        for (int a = 0; a < KS; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            cycle();
            check(tag, 32'(rd_data), 32'(base) + a);
        end
    endtask

    initial begin
        int start;
        int n5;
        logic p5;
        ap_rst_n        = 1'b1;
        input_V_dout    = '0;
        input_V_empty_n = 1'b0;
        rd_en           = 1'b0;
        rd_addr         = '0;
        bank_release    = 1'b0;
        dout5           = '0;
        empty_n5        = 1'b0;
        rd_en5          = 1'b0;
        rd_addr5        = '0;
        #2;
        do_reset();

        // 1: preloaded 1..4, consecutive pops, readback.
        for (int i = 1; i <= KS; i++) fifo_q.push_back(CW'(i));
        feed_en = 1'b1;
        pop_cyc_q.delete();
        run_pops(KS, 20, "t1_pops");
        check("t1_consecutive", pop_cyc_q[KS-1] - pop_cyc_q[0], KS - 1);
        check("t1_valid_next", 32'(bank_valid), 1);
        read_all("t1_rd", 16'd1);

        // 2: two kernels with no release, then WAIT until released.
        bank_release = 1'b1;
        cycle();
        for (int i = 10; i <= 21; i++) fifo_q.push_back(CW'(i));
        pop_cyc_q.delete();
        start = pop_cnt;
        run_pops(2 * KS, 30, "t2_pops");
        check("t2_consecutive", pop_cyc_q[2*KS-1] - pop_cyc_q[0], 2 * KS - 1);
        repeat (5) cycle();
        check("t2_wait_holds", pop_cnt - start, 2 * KS);
        bank_release = 1'b1;
        cycle();
        read_all("t2_rd", 16'd14);
        for (int k = 0; k < 10 && (pop_cnt - start) < 2 * KS + 1; k++) cycle();
        check("t2_resume", 32'(pop_cnt - start >= 2 * KS + 1), 1);

        // 3: empty_n toggling every other cycle with random reads and releases.
        for (int c = 0; c < 200; c++) begin
            feed_en = c[0];
            if (fifo_q.size() < 3) fifo_q.push_back(CW'($urandom));
            rd_en        = $urandom_range(0, 1) == 1;
            rd_addr      = AW'($urandom_range(0, KS - 1));
            bank_release = $urandom_range(0, 5) == 0;
            cycle();
        end

        // 4: release while nothing valid is ignored; rd_en while invalid reads 0.
        feed_en = 1'b0;
        for (int k = 0; k < 10 && ready_cnt > 0; k++) begin
            bank_release = 1'b1;
            cycle();
        end
        check("t4_drained", 32'(bank_valid), 0);
        rd_en   = 1'b1;
        rd_addr = '0;
        cycle();
        check("t4_rd_invalid", 32'(rd_data), 0);
        bank_release = 1'b1;
        cycle();
        check("t4_rel_ignored", 32'(bank_valid), 0);
        for (int i = 0; i < 2 * KS; i++) fifo_q.push_back(CW'($urandom));
        feed_en = 1'b1;
        wait_valid(20, "t4_valid");
        for (int a = 0; a < KS; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            cycle();
        end

        // 5: reset after 2 of 4 words discards the partial kernel.
        do_reset();
        for (int i = 0; i < KS; i++) fifo_q.push_back(CW'(16'h21 + i));
        run_pops(2, 10, "t5_partial");
        ap_rst_n = 1'b0;
        #1;
        model_clear();
        check("t5_rst_read", 32'(input_V_read), 0);
        check("t5_rst_valid", 32'(bank_valid), 0);
        check("t5_rst_rd", 32'(rd_data), 0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < KS; i++) fifo_q.push_back(CW'(16'h31 + i));
        wait_valid(20, "t5_valid");
        read_all("t5_rd", 16'h31);

`ifdef WLOAD_CHECKSUM_EN
        // 6: checksum of four 0xFFFF words.
        do_reset();
        for (int i = 0; i < KS; i++) fifo_q.push_back(16'hFFFF);
        wait_valid(20, "t6_valid");
        check("t6_sum", 32'(bank_sum), 32'h3FFFC);
`endif

        // Fully random traffic.
        for (int c = 0; c < 400; c++) begin
            feed_en = $urandom_range(0, 3) != 0;
            if (fifo_q.size() < 4) fifo_q.push_back(CW'($urandom));
            rd_en        = $urandom_range(0, 1) == 1;
            rd_addr      = AW'($urandom_range(0, KS - 1));
            bank_release = $urandom_range(0, 4) == 0;
            cycle();
        end

        // Out-of-range addresses on the KERN_SIZE=5 instance.
        n5 = 0;
        for (int k = 0; k < 20 && !valid5; k++) begin
            empty_n5 = n5 < 5;
            dout5    = CW'(100 + n5);
            @(negedge ap_clk);
            p5 = read5;
            @(posedge ap_clk);
            #1;
            if (p5) n5++;
        end
        empty_n5 = 1'b0;
        check("k5_pops", n5, 5);
        check("k5_valid", 32'(valid5), 1);
        for (int a = 0; a < 8; a++) begin
            rd_en5   = 1'b1;
            rd_addr5 = 3'(a);
            @(posedge ap_clk);
            #1;
            rd_en5 = 1'b0;
            check("k5_rd", 32'(rd_data5), (a < 5) ? 100 + a : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
